// File: rtl/ps2_scancode_receiver.sv
// PS/2 keyboard scancode receiver.
// This block synchronises and filters the raw ps2c/ps2d lines and deserialises
// 11-bit frames. It drops break (F0) and extended (E0) prefixes and emits one
// make code per keypress, marked by a single-cycle key_valid strobe.
//
// Output handshake: key_valid and frame_error are single-cycle strobes with no
// ready/backpressure. key_code and key_extended are valid while key_valid is
// high and hold their value until the next accepted code. The two strobes are
// never high in the same cycle.
module ps2_scancode_receiver #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2c,
    input  logic       ps2d,
    output logic [7:0] key_code,
    output logic       key_valid,
    output logic       key_extended,
    output logic       frame_error
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    state_t state, state_next;

    // Synchroniser and filter signals. The reset value 1 matches an idle bus.
    logic          c_meta, c_sync, d_meta, d_sync;
    logic [7:0]    filt_cnt;
    logic          filt_clk;
    logic          fall_pulse;

    // Frame datapath
    logic [2:0]    bitcnt, bitcnt_next;
    logic [7:0]    shreg, shreg_next;
    logic          parity_bit, parity_next;
    logic [TW-1:0] tcnt, tcnt_next;
    logic          brk_flag, brk_next;
    logic          ext_flag, ext_next;
    logic [7:0]    code_next;
    logic          kext_next, kv_next, fe_next;
    logic          frame_good;

    // Two-flop synchronisers on both raw PS/2 lines
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            c_meta <= 1'b1;
            c_sync <= 1'b1;
            d_meta <= 1'b1;
            d_sync <= 1'b1;
        end else begin
            c_meta <= ps2c;
            c_sync <= c_meta;
            d_meta <= ps2d;
            d_sync <= d_meta;
        end
    end

    // Glitch filter on ps2c: the level flips only after FILTER_LEN disagreeing samples
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            filt_cnt   <= 8'd0;
            filt_clk   <= 1'b1;
            fall_pulse <= 1'b0;
        end else begin
            fall_pulse <= 1'b0;
            if (c_sync != filt_clk) begin
                if (filt_cnt == 8'(FILTER_LEN - 1)) begin
                    filt_clk   <= c_sync;
                    filt_cnt   <= 8'd0;
                    fall_pulse <= ~c_sync;
                end else begin
                    filt_cnt <= filt_cnt + 8'd1;
                end
            end else begin
                filt_cnt <= 8'd0;
            end
        end
    end

    // Frame FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state, deserialiser, timeout and prefix decoder
    always_comb begin
        state_next  = state;
        bitcnt_next = bitcnt;
        shreg_next  = shreg;
        parity_next = parity_bit;
        tcnt_next   = tcnt;
        brk_next    = brk_flag;
        ext_next    = ext_flag;
        code_next   = key_code;
        kext_next   = key_extended;
        kv_next     = 1'b0;
        fe_next     = 1'b0;
        frame_good  = 1'b0;

        // Inactivity counter runs only inside a frame and restarts on each clock fall.
        if (state != IDLE) begin
            if (fall_pulse) begin
                tcnt_next = '0;
            end else begin
                tcnt_next = tcnt + TW'(1);
            end
        end

        case (state)
            IDLE: begin
                tcnt_next = '0;
                if (fall_pulse && !d_sync) begin
                    state_next  = DATA;
                    bitcnt_next = 3'd0;
                end
            end
            DATA: begin
                if (fall_pulse) begin
                    shreg_next  = {d_sync, shreg[7:1]};
                    bitcnt_next = bitcnt + 3'd1;
                    if (bitcnt == 3'd7) begin
                        state_next = PARITY;
                    end
                end
            end
            PARITY: begin
                if (fall_pulse) begin
                    parity_next = d_sync;
                    state_next  = STOP;
                end
            end
            STOP: begin
                if (fall_pulse) begin
                    state_next = IDLE;
                    frame_good = d_sync & (^{shreg, parity_bit});
                    if (!frame_good) begin
                        fe_next  = 1'b1;
                        brk_next = 1'b0;
                        ext_next = 1'b0;
                    end else begin
                        case (shreg)
                            8'hE0: ext_next = 1'b1;
                            8'hF0: brk_next = 1'b1;
                            8'h00, 8'hAA, 8'hFA, 8'hFE, 8'hFF: ;
                            default: begin
                                if (brk_flag) begin
                                    // Key release: swallow the code and forget the prefixes
                                    brk_next = 1'b0;
                                    ext_next = 1'b0;
                                end else begin
                                    code_next = shreg;
                                    kext_next = ext_flag;
                                    kv_next   = 1'b1;
                                    ext_next  = 1'b0;
                                end
                            end
                        endcase
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        // Abandon a stalled frame
        if (state != IDLE && !fall_pulse && tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
            state_next = IDLE;
            tcnt_next  = '0;
            fe_next    = 1'b1;
            kv_next    = 1'b0;
            brk_next   = 1'b0;
            ext_next   = 1'b0;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bitcnt       <= 3'd0;
            shreg        <= 8'd0;
            parity_bit   <= 1'b0;
            tcnt         <= '0;
            brk_flag     <= 1'b0;
            ext_flag     <= 1'b0;
            key_code     <= 8'h00;
            key_extended <= 1'b0;
            key_valid    <= 1'b0;
            frame_error  <= 1'b0;
        end else begin
            bitcnt       <= bitcnt_next;
            shreg        <= shreg_next;
            parity_bit   <= parity_next;
            tcnt         <= tcnt_next;
            brk_flag     <= brk_next;
            ext_flag     <= ext_next;
            key_code     <= code_next;
            key_extended <= kext_next;
            key_valid    <= kv_next;
            frame_error  <= fe_next;
        end
    end

endmodule

// File: tb/tb_ps2_scancode_receiver.sv
// Testbench for ps2_scancode_receiver. It drives PS/2 frames and checks the
// output strobes against a queue of expected results.
module tb_ps2_scancode_receiver;

    localparam int FL   = 8;
    localparam int TO   = 600;
    localparam int HALF = 40;

    logic       clk = 1'b0;
    logic       reset;
    logic       ps2c;
    logic       ps2d;
    logic [7:0] key_code;
    logic       key_valid;
    logic       key_extended;
    logic       frame_error;

    // Expected strobe items: {is_error, extended, code}
    logic [9:0] exp_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_fall_cyc = 0;
    int err_cyc = 0;
    bit err_seen = 0;
    logic prev_kv = 1'b0;

    ps2_scancode_receiver #(
        .FILTER_LEN    (FL),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ps2c        (ps2c),
        .ps2d        (ps2d),
        .key_code    (key_code),
        .key_valid   (key_valid),
        .key_extended(key_extended),
        .frame_error (frame_error)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        ps2d = b;
        wait_clks(HALF);
        ps2c = 1'b0;
        last_fall_cyc = cyc;
        wait_clks(HALF);
        ps2c = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit((~^b) ^ bad_par);
        send_bit(1'b1);
        wait_clks(HALF);
    endtask

    task automatic send_key(input logic [7:0] code, input bit ext);
        if (ext) send_frame(8'hE0, 1'b0);
        exp_q.push_back({1'b0, ext, code});
        send_frame(code, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        @(negedge clk);
        check({tag, "_code"}, key_code, 8'h00);
        check({tag, "_valid"}, key_valid, 0);
        check({tag, "_ext"}, key_extended, 0);
        check({tag, "_ferr"}, frame_error, 0);
        #1;
    endtask

    // Scoreboard monitor: every strobe must match the head of the queue
    always @(negedge clk) begin
        if (reset) begin
            prev_kv = 1'b0;
        end else begin
            if (key_valid && frame_error) check("both_strobes", 1, 0);
            if (key_valid) check("kv_width", prev_kv, 0);
            if (frame_error) begin
                err_seen = 1;
                err_cyc = cyc;
            end
            if (key_valid || frame_error) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_strobe", exp_q.size(), 1);
                end else begin
                    check("strobe", frame_error ? 10'h200 : {1'b0, key_extended, key_code},
                          exp_q.pop_front());
                end
            end
            prev_kv = key_valid;
        end
    end

    // Watchdog
    initial begin
        #5_000_000;
        errors++;
        $display("FAIL watchdog expired");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Stimulus
    initial begin
        int lat;
        logic [7:0] rc;
        bit re;
        reset = 1'b1;
        ps2c  = 1'b1;
        ps2d  = 1'b1;
        wait_clks(5);
        check_reset_outputs("rst");
        reset = 1'b0;
        wait_clks(20);

        // Plain make code
        send_key(8'h1C, 0);
        check("code_1c", key_code, 8'h1C);

        // Break sequence is swallowed
        send_key(8'h23, 0);
        send_frame(8'hF0, 0);
        send_frame(8'h1C, 0);
        check("code_hold_brk", key_code, 8'h23);
        send_key(8'h1C, 0);

        // Extended prefix followed by a plain key
        send_key(8'h75, 1);
        send_key(8'h72, 0);

        // Silently discarded bytes leave the flags untouched
        send_frame(8'hAA, 0);
        send_frame(8'hFA, 0);
        check("code_hold_disc", key_code, 8'h72);

        // Parity error
        exp_q.push_back(10'h200);
        send_frame(8'h2B, 1);
        check("code_hold_err", key_code, 8'h72);
        send_key(8'h2B, 0);

        // Typematic repeat
        send_key(8'h2B, 0);

        // Timeout: start bit plus four data bits, then the clock stays high
        exp_q.push_back(10'h200);
        err_seen = 0;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        for (int i = 0; i < TO + 100 && !err_seen; i++) wait_clks(1);
        check("timeout_seen", err_seen, 1);
        lat = err_cyc - last_fall_cyc;
        check("timeout_lat_ok", (lat >= TO + FL && lat <= TO + FL + 6), 1);
        wait_clks(20);
        send_key(8'h33, 0);

        // Glitch shorter than the filter with data low must not start a frame
        ps2d = 1'b0;
        @(posedge clk);
        #1;
        ps2c = 1'b0;
        wait_clks(FL - 1);
        ps2c = 1'b1;
        wait_clks(30);
        ps2d = 1'b1;
        send_key(8'h4D, 0);

        // Random make codes, some with an extended prefix
        for (int n = 0; n < 6; n++) begin
            rc = 8'($urandom_range(1, 8'h7F));
            re = 1'($urandom_range(0, 1));
            send_key(rc, re);
        end

        // Reset in the middle of a frame
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        reset = 1'b1;
        wait_clks(3);
        check_reset_outputs("midrst");
        ps2d = 1'b1;
        reset = 1'b0;
        wait_clks(20);
        send_key(8'h1B, 0);
        check("code_1b", key_code, 8'h1B);

        wait_clks(50);
        check("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_scancode_receiver.md
Name: ps2_scancode_receiver

Overview:
Upstream stage of the keyboard path. Deserialises PS/2 keyboard frames from the raw ps2c/ps2d lines and strips break (F0) and extended (E0) prefixes. Emits one make-code byte per keypress on key_code with a one-cycle key_valid strobe. key_code drives the scancode-to-ASCII translator combinationally; key_valid tells the microcontroller interface when to latch the translated byte.

Parameters:
FILTER_LEN, 8, number of consecutive identical synchronised samples required before the filtered ps2c level changes (range 2..255)
TIMEOUT_CYCLES, 200000, clk cycles without a ps2c falling edge, while inside a frame, before the frame is abandoned (2 ms at 100 MHz)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
ps2c  input  1  raw PS/2 clock from keyboard (asynchronous)
ps2d  input  1  raw PS/2 data from keyboard (asynchronous)
key_code  output  8  last accepted make-code scancode, held until the next accepted code
key_valid  output  1  one-cycle strobe: key_code/key_extended updated this cycle
key_extended  output  1  1 if the accepted code was preceded by E0
frame_error  output  1  one-cycle strobe: parity error, bad stop bit or timeout

Behaviour:
- Reset (async, active-high): key_code=8'h00, key_valid=0, key_extended=0, frame_error=0. FSM goes to IDLE; bit counter, shift register, timeout counter, break flag and ext flag cleared. Synchroniser and filter outputs preset to 1 (idle bus). Reset mid-frame discards the partial frame with no strobe.
- Sync: ps2c and ps2d each pass through a 2-flop synchroniser.
- Filter: counter on synced ps2c. Filtered clock changes only after FILTER_LEN consecutive samples differ from the current filtered value; any equal sample clears the counter. A falling edge is filtered 1->0; it yields a one-cycle internal fall pulse.
- Data is sampled from synced ps2d in the fall-pulse cycle.
- Frame FSM, one data sample per fall pulse:
  - IDLE: sample 0 (start bit) -> DATA, bitcnt=0. Sample 1 -> stay IDLE, no error.
  - DATA: shift LSB first; after the 8th bit -> PARITY.
  - PARITY: store bit -> STOP.
  - STOP: frame is good if stop=1 and the total ones in data+parity are odd. Always return to IDLE.
- Timeout: in any state except IDLE, a counter runs and clears on each fall pulse. At TIMEOUT_CYCLES: pulse frame_error, return to IDLE, clear break/ext flags.
- Bad frame: frame_error pulses in the cycle after the STOP sample. The byte is discarded and break/ext flags are cleared.
- Good frame: the byte goes to the decoder in the cycle after the STOP sample.
  - E0 -> set ext flag, no output.
  - F0 -> set break flag, no output.
  - 00, AA, FA, FE, FF -> discarded silently, flags unchanged.
  - Any other byte with break flag=1 -> discarded (key release); clear both flags.
  - Any other byte with break flag=0 -> key_code<=byte, key_extended<=ext, key_valid=1 for exactly one cycle; clear ext flag.
- Latency: key_valid and frame_error assert 1 clk after the fall-pulse cycle of the stop bit.
- Typematic repeats (same make code resent) each produce a key_valid.
- frame_error and key_valid are never asserted in the same cycle.
- ps2c edges arriving while a strobe is high are processed normally; no backpressure.

Test Plan:
- Frame 0x1C (start 0, data LSB first, parity 0, stop 1) at 12.5 kHz, FILTER_LEN=8 -> key_code=8'h1C, key_extended=0, key_valid high exactly 1 clk; frame_error never asserted.
- Frames F0, 1C after a prior make 0x23 -> no key_valid; key_code stays 8'h23. Next frame 0x1C -> key_valid with key_code=8'h1C.
- Frames E0, 75 -> single key_valid, key_code=8'h75, key_extended=1. A following plain 0x72 -> key_extended=0.
- Frame 0x2B with parity bit inverted -> frame_error 1 clk, no key_valid, key_code unchanged. Next good 0x2B -> accepted.
- Start bit plus 4 data bits, then ps2c held high -> frame_error exactly TIMEOUT_CYCLES (+sync/filter delay) after the last edge. A subsequent good 0x33 is decoded correctly.
- ps2c glitches low for FILTER_LEN-1 cycles in idle -> no bit sampled. Assert reset mid-frame, then send 0x1B -> outputs return to reset values, then key_code=8'h1B with one key_valid.
